// File: rtl/y86_alu_if.sv
// Execute-stage <-> ALU bus: operands and op select in, registered result/overflow out.
// Y86_ALU_CC_EN adds the zf/sf/of condition-code outputs.
interface y86_alu_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       control;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             overflow;
`ifdef Y86_ALU_CC_EN
  logic             zf;
  logic             sf;
  logic             of;
`endif

`ifdef Y86_ALU_CC_EN
  modport master (
    output in_valid, a, b, control,
    input  out_valid, result, overflow, zf, sf, of
  );
  modport slave (
    input  in_valid, a, b, control,
    output out_valid, result, overflow, zf, sf, of
  );
`else
  modport master (
    output in_valid, a, b, control,
    input  out_valid, result, overflow
  );
  modport slave (
    input  in_valid, a, b, control,
    output out_valid, result, overflow
  );
`endif
endinterface

// File: rtl/y86_alu.sv
// Registered Y86-64 ALU (ADD/SUB/AND/XOR) with signed overflow, one-cycle latency.
// Y86_ALU_CC_EN adds registered zf/sf/of condition codes.
module y86_alu #(
  parameter int WIDTH = 64
) (
  input logic       clk,
  input logic       rst,
  y86_alu_if.slave  bus
);
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } alu_op_t;

  alu_op_t          op;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] next_result;
  logic             next_overflow;
  logic             add_overflow;

  assign op = alu_op_t'(bus.control);

  // Subtraction reuses the adder chain as a + ~b + 1; carry-out is dropped.
  always_comb begin
    logic carry;
    b_eff = (op == OP_SUB) ? ~bus.b : bus.b;
    carry = (op == OP_SUB);
    sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = bus.a[i] ^ b_eff[i] ^ carry;
      carry  = (bus.a[i] & b_eff[i]) | (carry & (bus.a[i] ^ b_eff[i]));
    end
  end

  // Same-sign addends producing an opposite-sign sum; b_eff covers the SUB case too.
  assign add_overflow = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) &&
                        (sum[WIDTH-1] != bus.a[WIDTH-1]);

  always_comb begin
    next_result   = sum;
    next_overflow = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB: begin
        next_result   = sum;
        next_overflow = add_overflow;
      end
      OP_AND: next_result = bus.a & bus.b;
      OP_XOR: next_result = bus.a ^ bus.b;
      default: begin
        next_result   = sum;
        next_overflow = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.overflow  <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.result   <= next_result;
        bus.overflow <= next_overflow;
      end
    end
  end

`ifdef Y86_ALU_CC_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.zf <= 1'b0;
      bus.sf <= 1'b0;
      bus.of <= 1'b0;
    end else if (bus.in_valid) begin
      bus.zf <= (next_result == '0);
      bus.sf <= next_result[WIDTH-1];
      bus.of <= next_overflow;
    end
  end
`endif

endmodule

// File: tb/tb_y86_alu.sv
// Scoreboard bench for y86_alu: directed boundary cases plus randomized ops against
// an arithmetic reference model; Y86_ALU_CC_EN also checks zf/sf/of.
module tb_y86_alu;
  localparam int WIDTH = 64;
  localparam logic signed [WIDTH:0] SMAX = 65'sd9223372036854775807;
  localparam logic signed [WIDTH:0] SMIN = -SMAX - 65'sd1;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             zf;
    logic             sf;
    logic             of;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  y86_alu_if #(.WIDTH(WIDTH)) bus ();
  y86_alu #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t             sb[$];
  int               checks = 0;
  int               failures = 0;
  logic [WIDTH-1:0] last_result;

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: exact integer arithmetic on sign-extended values, then range test.
  function automatic exp_t model(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
    exp_t e;
    logic signed [WIDTH:0] wide;
    wide = '0;
    e = '0;
    case (op)
      2'b00: wide = $signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b});
      2'b01: wide = $signed({a[WIDTH-1], a}) - $signed({b[WIDTH-1], b});
      default: wide = '0;
    endcase
    case (op)
      2'b00, 2'b01: begin
        e.result   = wide[WIDTH-1:0];
        e.overflow = (wide > SMAX) || (wide < SMIN);
      end
      2'b10: e.result = a & b;
      default: e.result = a ^ b;
    endcase
    e.zf = (e.result == 0);
    e.sf = e.result[WIDTH-1];
    e.of = e.overflow;
    return e;
  endfunction

  task automatic applyStimulus(input logic [1:0] op, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b);
    exp_t e;
    e = model(op, a, b);
    bus.in_valid = 1'b1;
    bus.control  = op;
    bus.a        = a;
    bus.b        = b;
    sb.push_back(e);
    last_result = e.result;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [WIDTH-1:0] pickOperand();
    logic [WIDTH-1:0] v;
    case ($urandom_range(0, 5))
      0: v = {1'b0, {(WIDTH-1){1'b1}}};
      1: v = {1'b1, {(WIDTH-1){1'b0}}};
      2: v = WIDTH'($urandom_range(0, 15));
      3: v = '1;
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  // Monitor: every presented output must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_out_valid actual=1 expected=0 at %0t", $time);
      end else begin
        e = sb.pop_front();
        checkOutput("result", bus.result, e.result);
        checkOutput("overflow", WIDTH'(bus.overflow), WIDTH'(e.overflow));
`ifdef Y86_ALU_CC_EN
        checkOutput("zf", WIDTH'(bus.zf), WIDTH'(e.zf));
        checkOutput("sf", WIDTH'(bus.sf), WIDTH'(e.sf));
        checkOutput("of", WIDTH'(bus.of), WIDTH'(e.of));
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.control  = 2'b00;
    last_result  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", WIDTH'(bus.out_valid), '0);
    checkOutput("reset_result", bus.result, '0);
    checkOutput("reset_overflow", WIDTH'(bus.overflow), '0);
`ifdef Y86_ALU_CC_EN
    checkOutput("reset_zf", WIDTH'(bus.zf), '0);
    checkOutput("reset_sf", WIDTH'(bus.sf), '0);
    checkOutput("reset_of", WIDTH'(bus.of), '0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    applyStimulus(2'b00, 64'd5, 64'd7);
    applyStimulus(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    applyStimulus(2'b01, 64'd9, 64'd9);
    applyStimulus(2'b01, 64'h8000_0000_0000_0000, 64'd1);
    applyStimulus(2'b10, 64'hF0F0, 64'hFF00);
    applyStimulus(2'b11, 64'hFFFF, 64'h00FF);
    idle(2);

    applyStimulus(2'b00, 64'd1, 64'd1);
    applyStimulus(2'b01, 64'd3, 64'd5);
    applyStimulus(2'b11, 64'd6, 64'd6);
    idle(1);
    @(negedge clk);
    checkOutput("idle_out_valid", WIDTH'(bus.out_valid), '0);
    checkOutput("idle_hold_result", bus.result, last_result);
    @(posedge clk);
    #1;

    applyStimulus(2'b00, 64'd40, 64'd2);
    idle(1);
    // Op sampled in the reset cycle must vanish without a trace.
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.control  = 2'b00;
    bus.a        = 64'd1;
    bus.b        = 64'd2;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    last_result  = '0;
    @(negedge clk);
    checkOutput("rst_mid_out_valid", WIDTH'(bus.out_valid), '0);
    checkOutput("rst_mid_result", bus.result, '0);
    checkOutput("rst_mid_overflow", WIDTH'(bus.overflow), '0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 300; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), pickOperand(), pickOperand());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(3);
    @(negedge clk);
    checkOutput("idle_hold_final", bus.result, last_result);
    checkOutput("scoreboard_drained", WIDTH'(sb.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
